// File: rtl/vga_timing_pkg.sv
// Raster constants for the 1024x768 @60 Hz pixel-timing bus.
// The draw stages share these for their blank and coordinate compares.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned H_ACTIVE = 1024;
  localparam int unsigned H_FP     = 24;
  localparam int unsigned H_SYNC   = 136;
  localparam int unsigned H_BP     = 160;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;

  localparam int unsigned V_ACTIVE = 768;
  localparam int unsigned V_FP     = 3;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BP     = 29;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with registered blank/sync flags derived
// from the next-state count, so a count and its flags always change together.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = H_TOTAL,
  parameter int unsigned ACTIVE     = H_ACTIVE,
  parameter int unsigned SYNC_START = HS_START,
  parameter int unsigned SYNC_END   = HS_END
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output cnt_t count,
  output logic blank,
  output logic sync,
  output logic wrap
);

  localparam cnt_t LAST_C   = cnt_t'(TOTAL - 1);
  localparam cnt_t ACTIVE_C = cnt_t'(ACTIVE);
  localparam cnt_t SS_C     = cnt_t'(SYNC_START);
  localparam cnt_t SE_C     = cnt_t'(SYNC_END);

  cnt_t count_d, count_q;
  logic blank_d, blank_q;
  logic sync_d, sync_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    wrap    = en && (count_q == LAST_C);
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + cnt_t'(1);
    end
    blank_d = (count_d >= ACTIVE_C);
    sync_d  = (count_d >= SS_C) && (count_d < SE_C);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      blank_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign blank = blank_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Source of the pixel-timing bus: horizontal and vertical axis counters plus
// a registered frame_start pulse on the simultaneous h/v wrap.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        en,
  output logic [11:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;

  logic h_wrap, v_en, v_wrap;
  logic frame_start_d, frame_start_q;

  assign v_en = en & h_wrap;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (HS_START),
    .SYNC_END   (HS_START + H_SYNC)
  ) u_h_axis (
    .clk   (pclk),
    .rst_n (reset),
    .en    (en),
    .count (hcount_out),
    .blank (hblnk_out),
    .sync  (hsync_out),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (VS_START),
    .SYNC_END   (VS_START + V_SYNC)
  ) u_v_axis (
    .clk   (pclk),
    .rst_n (reset),
    .en    (v_en),
    .count (vcount_out),
    .blank (vblnk_out),
    .sync  (vsync_out),
    .wrap  (v_wrap)
  );

  // v_wrap already implies en and an h wrap, so the pulse self-clears next edge.
  always_comb begin
    frame_start_d = v_wrap;
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: a full-size instance for horizontal/enable/reset behaviour and
// a narrow-line instance (real vertical timing) so whole frames fit in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] hc;
    logic [11:0] vc;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        fs;
  } obs_t;

  typedef struct {
    int    cyc;
    bit    ph;
    bit    sel;
    obs_t  exp;
    string name;
  } item_t;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst_f, en_f, rst_v, en_v;

  logic [11:0] hc_f, vc_f, hc_v, vc_v;
  logic hs_f, hb_f, vs_f, vb_f, fs_f;
  logic hs_v, hb_v, vs_v, vb_v, fs_v;

  vga_timing_gen dut_f (
    .pclk        (pclk),
    .reset       (rst_f),
    .en          (en_f),
    .hcount_out  (hc_f),
    .hsync_out   (hs_f),
    .hblnk_out   (hb_f),
    .vcount_out  (vc_f),
    .vsync_out   (vs_f),
    .vblnk_out   (vb_f),
    .frame_start (fs_f)
  );

  // 25-pixel lines: active 0..15, sync 18..20, real 806-line vertical timing.
  vga_timing_gen #(
    .H_ACTIVE (16),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (4)
  ) dut_v (
    .pclk        (pclk),
    .reset       (rst_v),
    .en          (en_v),
    .hcount_out  (hc_v),
    .hsync_out   (hs_v),
    .hblnk_out   (hb_v),
    .vcount_out  (vc_v),
    .vsync_out   (vs_v),
    .vblnk_out   (vb_v),
    .frame_start (fs_v)
  );

  obs_t act_f, act_v;
  assign act_f = {hc_f, vc_f, hs_f, hb_f, vs_f, vb_f, fs_f};
  assign act_v = {hc_v, vc_v, hs_v, hb_v, vs_v, vb_v, fs_v};

  item_t sb[$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic obs_t mk(input int hc, input int vc, input bit hs, input bit hb,
                              input bit vs, input bit vb, input bit fs);
    obs_t o;
    o.hc = 12'(hc);
    o.vc = 12'(vc);
    o.hs = hs;
    o.hb = hb;
    o.vs = vs;
    o.vb = vb;
    o.fs = fs;
    return o;
  endfunction

  task automatic expect_now(input bit sel, input bit ph, input string name, input obs_t e);
    item_t it;
    it.cyc  = cyc;
    it.ph   = ph;
    it.sel  = sel;
    it.exp  = e;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hc=%0d vc=%0d hs=%b hb=%b vs=%b vb=%b fs=%b, want hc=%0d vc=%0d hs=%b hb=%b vs=%b vb=%b fs=%b",
               name, act.hc, act.vc, act.hs, act.hb, act.vs, act.vb, act.fs,
               exp.hc, exp.vc, exp.hs, exp.hb, exp.vs, exp.vb, exp.fs);
    end
  endtask

  task automatic drain(input bit ph);
    item_t it;
    while (sb.size() > 0 && (sb[0].cyc < cyc || (sb[0].cyc == cyc && sb[0].ph <= ph))) begin
      it = sb.pop_front();
      if (it.cyc != cyc || it.ph != ph) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: sampled late at cycle %0d phase %0d, wanted cycle %0d phase %0d",
                 it.name, cyc, ph, it.cyc, it.ph);
      end else begin
        check(it.name, it.sel ? act_v : act_f, it.exp);
      end
    end
  endtask

  // Monitor: phase 0 at the falling edge, phase 1 just before the next rising edge.
  initial begin
    forever begin
      @(negedge pclk);
      drain(1'b0);
      #3;
      drain(1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic adv(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    rst_f = 1'b1;
    rst_v = 1'b1;
    en_f  = 1'b0;
    en_v  = 1'b0;
    #1;
    rst_f = 1'b0;
    rst_v = 1'b0;
    adv(2);
    expect_now(0, 0, "f_reset_state", mk(0, 0, 0, 0, 0, 0, 0));
    expect_now(1, 0, "v_reset_state", mk(0, 0, 0, 0, 0, 0, 0));

    // Vertical boundaries and frame period on the narrow-line instance.
    rst_v = 1'b1;
    en_v  = 1'b1;
    adv(19199); expect_now(1, 0, "v_line767_end",   mk(24, 767, 0, 1, 0, 0, 0));
    adv(1);     expect_now(1, 0, "v_line768_blank", mk(0, 768, 0, 0, 0, 1, 0));
    adv(75);    expect_now(1, 0, "v_line771_sync",  mk(0, 771, 0, 0, 1, 1, 0));
    adv(149);   expect_now(1, 0, "v_line776_sync",  mk(24, 776, 0, 1, 1, 1, 0));
    adv(1);     expect_now(1, 0, "v_line777_nosync", mk(0, 777, 0, 0, 0, 1, 0));
    adv(724);   expect_now(1, 0, "v_last_pixel",    mk(24, 805, 0, 1, 0, 1, 0));
    adv(1);     expect_now(1, 0, "v_frame_start",   mk(0, 0, 0, 0, 0, 0, 1));
    adv(1);     expect_now(1, 0, "v_frame_pulse_end", mk(1, 0, 0, 0, 0, 0, 0));
    adv(20149); expect_now(1, 0, "v_frame_period",  mk(0, 0, 0, 0, 0, 0, 1));
    en_v = 1'b0;
    adv(1);     expect_now(1, 0, "v_pulse_clears_en_low", mk(0, 0, 0, 0, 0, 0, 0));

    // Horizontal boundaries on the full-size instance.
    rst_f = 1'b1;
    en_f  = 1'b1;
    adv(1);     expect_now(0, 0, "f_first_edge",   mk(1, 0, 0, 0, 0, 0, 0));
    adv(1022);  expect_now(0, 0, "f_h1023",        mk(1023, 0, 0, 0, 0, 0, 0));
    adv(1);     expect_now(0, 0, "f_h1024_blank",  mk(1024, 0, 0, 1, 0, 0, 0));
    adv(23);    expect_now(0, 0, "f_h1047_nosync", mk(1047, 0, 0, 1, 0, 0, 0));
    adv(1);     expect_now(0, 0, "f_h1048_sync",   mk(1048, 0, 1, 1, 0, 0, 0));
    adv(135);   expect_now(0, 0, "f_h1183_sync",   mk(1183, 0, 1, 1, 0, 0, 0));
    adv(1);     expect_now(0, 0, "f_h1184_nosync", mk(1184, 0, 0, 1, 0, 0, 0));
    adv(159);   expect_now(0, 0, "f_h1343",        mk(1343, 0, 0, 1, 0, 0, 0));
    adv(1);     expect_now(0, 0, "f_hwrap_line1",  mk(0, 1, 0, 0, 0, 0, 0));
    adv(500);   expect_now(0, 0, "f_h500",         mk(500, 1, 0, 0, 0, 0, 0));

    en_f = 1'b0;
    adv(10);    expect_now(0, 0, "f_frozen",       mk(500, 1, 0, 0, 0, 0, 0));
    en_f = 1'b1;
    adv(1);     expect_now(0, 0, "f_resume",       mk(501, 1, 0, 0, 0, 0, 0));
    adv(199);   expect_now(0, 0, "f_h700",         mk(700, 1, 0, 0, 0, 0, 0));

    // Asynchronous reset mid-cycle, checked before the next rising edge.
    @(negedge pclk);
    #1;
    rst_f = 1'b0;
    expect_now(0, 1, "f_async_reset", mk(0, 0, 0, 0, 0, 0, 0));
    adv(2);     expect_now(0, 0, "f_reset_held",   mk(0, 0, 0, 0, 0, 0, 0));
    rst_f = 1'b1;
    expect_now(0, 0, "f_release_no_pulse", mk(0, 0, 0, 0, 0, 0, 0));
    adv(1);     expect_now(0, 0, "f_restart",      mk(1, 0, 0, 0, 0, 0, 0));
    adv(1343);  expect_now(0, 0, "f_restart_line1", mk(0, 1, 0, 0, 0, 0, 0));

    adv(2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: %0d expectations left unchecked, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
